// File: rtl/hack_data_memory.sv
// hack_data_memory: Hack CPU data-port responder (RAM / SCREEN / KBD) plus a screen-write FIFO toward the display.
// Latency: inM is combinational from addressM; writes, KBD loads and FIFO pushes land at the rising edge.
// Backpressure: never stalls the CPU; a screen push into a full FIFO with no pop is dropped and flagged in scr_overflow.
// Optional: define HACK_MEM_BOUNDS_TRAP_EN to enable the sticky bad_addr / bad_addr_val trap.

// Small generic FIFO: head shown combinationally, full+pop on one edge accepts the push.
module hack_mem_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign head_vld = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = head_vld && pop_rdy;
  // A pop on the same edge frees the slot the push needs.
  assign do_push  = push_vld && (!full || do_pop);
  assign drop     = push_vld && full && !do_pop;
  assign head_dat = mem[rd_ptr];

  // Pointer/count update; reset discards pending entries and blocks push/pop on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module hack_data_memory #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow,
  output logic        bad_addr,
  output logic [14:0] bad_addr_val
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam logic [14:0] RAM_END  = 15'(RAM_WORDS);
  localparam logic [14:0] SCR_BASE = 15'd16384;
  localparam logic [14:0] SCR_END  = 15'(16384 + SCREEN_WORDS);
  localparam logic [14:0] KBD_ADDR = 15'd24576;

  logic [15:0] ram     [RAM_WORDS];
  logic [15:0] scr_mem [SCREEN_WORDS];
  logic [15:0] kbd_reg;

  logic        ram_hit;
  logic        scr_hit;
  logic        kbd_hit;
  logic [12:0] scr_off;
  logic        scr_push;
  logic        fifo_drop;
  logic [28:0] fifo_head;

  assign ram_hit  = (addressM < RAM_END);
  assign scr_hit  = (addressM >= SCR_BASE) && (addressM < SCR_END);
  assign kbd_hit  = (addressM == KBD_ADDR);
  // Screen base is 8K-aligned, so the low 13 address bits are the screen offset.
  assign scr_off  = addressM[12:0];
  assign scr_push = writeM && scr_hit;

  // Read mux: old contents are visible during a same-address write; unmapped reads as 0.
  always_comb begin
    inM = '0;
    if (ram_hit) begin
      inM = ram[addressM[RAM_AW-1:0]];
    end else if (scr_hit) begin
      inM = scr_mem[scr_off[SCR_AW-1:0]];
    end else if (kbd_hit) begin
      inM = kbd_reg;
    end
  end

  // Storage writes: RAM and screen RAM are never cleared, screen RAM updates even when the FIFO drops.
  always_ff @(posedge clk) begin
    if (writeM && ram_hit) begin
      ram[addressM[RAM_AW-1:0]] <= outM;
    end
    if (scr_push) begin
      scr_mem[scr_off[SCR_AW-1:0]] <= outM;
    end
  end

  // Keyboard register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_reg      <= '0;
      scr_overflow <= 1'b0;
    end else begin
      if (kbd_valid) begin
        kbd_reg <= kbd_code;
      end
      if (fifo_drop) begin
        scr_overflow <= 1'b1;
      end
    end
  end

  hack_mem_fifo #(
    .WIDTH(29),
    .DEPTH(FIFO_DEPTH)
  ) u_scr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (scr_push),
    .push_dat ({scr_off, outM}),
    .pop_rdy  (scr_ready),
    .head_vld (scr_valid),
    .head_dat (fifo_head),
    .drop     (fifo_drop)
  );

  assign scr_addr = fifo_head[28:16];
  assign scr_data = fifo_head[15:0];

`ifdef HACK_MEM_BOUNDS_TRAP_EN
  logic trap_hit;
  assign trap_hit = (addressM > KBD_ADDR) || (writeM && kbd_hit);

  // Sticky trap: latch the first out-of-map access and hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_addr     <= 1'b0;
      bad_addr_val <= '0;
    end else if (trap_hit && !bad_addr) begin
      bad_addr     <= 1'b1;
      bad_addr_val <= addressM;
    end
  end
`else
  assign bad_addr     = 1'b0;
  assign bad_addr_val = '0;
`endif
endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: directed table, multi-cycle FIFO corner sequences, then random traffic vs a queue model.
module tb_hack_data_memory;
  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic        scr_overflow;
  logic        bad_addr;
  logic [14:0] bad_addr_val;

  always #5 clk = ~clk;

  hack_data_memory dut (
    .clk          (clk),
    .reset        (reset),
    .addressM     (addressM),
    .writeM       (writeM),
    .outM         (outM),
    .inM          (inM),
    .kbd_code     (kbd_code),
    .kbd_valid    (kbd_valid),
    .scr_addr     (scr_addr),
    .scr_data     (scr_data),
    .scr_valid    (scr_valid),
    .scr_ready    (scr_ready),
    .scr_overflow (scr_overflow),
    .bad_addr     (bad_addr),
    .bad_addr_val (bad_addr_val)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int DEPTH = 8;
  typedef struct {
    logic [12:0] a;
    logic [15:0] d;
  } ent_t;

  logic [15:0] m_ram [16384];
  bit          m_ram_ok [16384];
  logic [15:0] m_scr [8192];
  bit          m_scr_ok [8192];
  logic [15:0] m_kbd = '0;
  bit          m_ovf = 0;
  bit          m_bad = 0;
  logic [14:0] m_bad_val = '0;
  bit          m_init = 0;
  ent_t        m_q[$];

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int a;
    ent_t e;
    a = int'(addressM);
    if (reset) begin
      m_q.delete();
      m_kbd = '0;
      m_ovf = 0;
      m_bad = 0;
      m_bad_val = '0;
      m_init = 1;
      return;
    end
`ifdef HACK_MEM_BOUNDS_TRAP_EN
    if (!m_bad && (a >= 24577 || (writeM && a == 24576))) begin
      m_bad = 1;
      m_bad_val = addressM;
    end
`endif
    if (m_q.size() != 0 && scr_ready) m_q.delete(0);
    if (writeM) begin
      if (a < 16384) begin
        m_ram[a] = outM;
        m_ram_ok[a] = 1;
      end else if (a < 24576) begin
        m_scr[a - 16384] = outM;
        m_scr_ok[a - 16384] = 1;
        if (m_q.size() < DEPTH) begin
          e.a = 13'(a - 16384);
          e.d = outM;
          m_q.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (kbd_valid) m_kbd = kbd_code;
  endtask

  task automatic model_read(output logic [15:0] v, output bit ok);
    int a;
    a = int'(addressM);
    ok = 1;
    v = '0;
    if (a < 16384) begin
      ok = m_ram_ok[a];
      v = m_ram[a];
    end else if (a < 24576) begin
      ok = m_scr_ok[a - 16384];
      v = m_scr[a - 16384];
    end else if (a == 24576) begin
      v = m_kbd;
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] v;
    bit ok;
    if (!m_init) return;
    model_read(v, ok);
    if (ok) check({tag, ".inM"}, 32'(inM), 32'(v));
    check({tag, ".scr_valid"}, 32'(scr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check({tag, ".scr_addr"}, 32'(scr_addr), 32'(m_q[0].a));
      check({tag, ".scr_data"}, 32'(scr_data), 32'(m_q[0].d));
    end
    check({tag, ".scr_overflow"}, 32'(scr_overflow), 32'(m_ovf));
    check({tag, ".bad_addr"}, 32'(bad_addr), 32'(m_bad));
    check({tag, ".bad_addr_val"}, 32'(bad_addr_val), 32'(m_bad_val));
  endtask

  // One clock: update the model with the driven inputs, then step past the edge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input int a, input bit w, input int d,
                       input int kc, input bit kv, input bit rdy);
    reset     = rst;
    addressM  = 15'(a);
    writeM    = w;
    outM      = 16'(d);
    kbd_code  = 16'(kc);
    kbd_valid = kv;
    scr_ready = rdy;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rst;
    int          a;
    bit          w;
    int          d;
    int          kc;
    bit          kv;
    bit          rdy;
    bit          ci;    // check inM
    logic [15:0] ein;
    bit          cq;    // check FIFO state / overflow
    bit          ev;
    logic [12:0] ea;
    logic [15:0] ed;
    bit          eo;
  } vec_t;

  vec_t tbl [14];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{1, 0,     0, 0,       0,  0, 0, 0, 16'd0,     0, 0, 13'd0, 16'd0,     0};
    tbl[1]  = '{0, 1000,  1, 12345,   0,  0, 0, 0, 16'd0,     1, 0, 13'd0, 16'd0,     0};
    tbl[2]  = '{0, 1000,  0, 0,       0,  0, 0, 1, 16'd12345, 1, 0, 13'd0, 16'd0,     0};
    tbl[3]  = '{0, 16384, 1, 'hAAAA,  0,  0, 0, 0, 16'd0,     1, 0, 13'd0, 16'd0,     0};
    tbl[4]  = '{0, 16384, 0, 0,       0,  0, 0, 1, 16'hAAAA,  1, 1, 13'd0, 16'hAAAA,  0};
    tbl[5]  = '{0, 1000,  0, 0,       0,  0, 1, 1, 16'd12345, 1, 1, 13'd0, 16'hAAAA,  0};
    tbl[6]  = '{0, 1000,  1, 777,     0,  0, 0, 1, 16'd12345, 1, 0, 13'd0, 16'd0,     0};
    tbl[7]  = '{0, 1000,  0, 0,       0,  0, 0, 1, 16'd777,   1, 0, 13'd0, 16'd0,     0};
    tbl[8]  = '{0, 24576, 0, 0,       65, 1, 0, 1, 16'd0,     1, 0, 13'd0, 16'd0,     0};
    tbl[9]  = '{0, 24576, 1, 5,       0,  0, 0, 1, 16'd65,    1, 0, 13'd0, 16'd0,     0};
    tbl[10] = '{0, 24576, 0, 0,       0,  0, 0, 1, 16'd65,    1, 0, 13'd0, 16'd0,     0};
    tbl[11] = '{0, 30000, 1, 9,       0,  0, 0, 1, 16'd0,     1, 0, 13'd0, 16'd0,     0};
    tbl[12] = '{0, 24576, 0, 0,       0,  1, 1, 1, 16'd65,    1, 0, 13'd0, 16'd0,     0};
    tbl[13] = '{0, 24576, 0, 0,       0,  0, 0, 1, 16'd0,     1, 0, 13'd0, 16'd0,     0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].kc, tbl[i].kv, tbl[i].rdy);
      #1;
      if (tbl[i].ci) check($sformatf("tbl%0d.inM", i), 32'(inM), 32'(tbl[i].ein));
      if (tbl[i].cq) begin
        check($sformatf("tbl%0d.scr_valid", i), 32'(scr_valid), 32'(tbl[i].ev));
        check($sformatf("tbl%0d.scr_overflow", i), 32'(scr_overflow), 32'(tbl[i].eo));
        if (tbl[i].ev) begin
          check($sformatf("tbl%0d.scr_addr", i), 32'(scr_addr), 32'(tbl[i].ea));
          check($sformatf("tbl%0d.scr_data", i), 32'(scr_data), 32'(tbl[i].ed));
        end
      end
      cyc();
    end

    // ---- overflow: 9 writes into an 8-deep FIFO with the display stalled ----
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 1; i <= 9; i++) begin
      drive(0, 16384 + i, 1, i, 0, 0, 0);
      cyc();
    end
    drive(0, 16384 + 9, 0, 0, 0, 0, 0);
    #1;
    check("ovf.dropped_in_ram", 32'(inM), 32'd9);
    check("ovf.flag", 32'(scr_overflow), 32'd1);
    check("ovf.valid", 32'(scr_valid), 32'd1);
    scr_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("ovf.drain%0d.data", k), 32'(scr_data), 32'(k));
      check($sformatf("ovf.drain%0d.addr", k), 32'(scr_addr), 32'(k));
      check($sformatf("ovf.drain%0d.valid", k), 32'(scr_valid), 32'd1);
      cyc();
    end
    #1;
    check("ovf.empty", 32'(scr_valid), 32'd0);
    check("ovf.sticky", 32'(scr_overflow), 32'd1);

    // ---- full FIFO, push and pop on the same edge ----
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      drive(0, 16384 + 100 + i, 1, 10 + i, 0, 0, 0);
      cyc();
    end
    drive(0, 16384 + 200, 1, 77, 0, 0, 1);
    #1;
    check("fullpp.head_before", 32'(scr_data), 32'd10);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("fullpp.no_overflow", 32'(scr_overflow), 32'd0);
    scr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fullpp.drain%0d.valid", k), 32'(scr_valid), 32'd1);
      check($sformatf("fullpp.drain%0d.data", k), 32'(scr_data), (k < 7) ? 32'(11 + k) : 32'd77);
      check($sformatf("fullpp.drain%0d.addr", k), 32'(scr_addr), (k < 7) ? 32'(101 + k) : 32'd200);
      cyc();
    end
    #1;
    check("fullpp.empty", 32'(scr_valid), 32'd0);

    // ---- reset mid-stream discards pending entries and clears KBD ----
    for (int i = 0; i < 3; i++) begin
      drive(0, 16384 + 50 + i, 1, 500 + i, 42, 1, 0);
      cyc();
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    cyc();
    drive(0, 24576, 0, 0, 0, 0, 0);
    #1;
    check("rstmid.valid", 32'(scr_valid), 32'd0);
    check("rstmid.kbd", 32'(inM), 32'd0);
    check("rstmid.ovf", 32'(scr_overflow), 32'd0);
    check("rstmid.bad", 32'(bad_addr), 32'd0);
    cyc();

`ifdef HACK_MEM_BOUNDS_TRAP_EN
    // ---- bounds trap: first offender is kept ----
    drive(0, 30000, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 25000, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("trap.flag", 32'(bad_addr), 32'd1);
    check("trap.val", 32'(bad_addr_val), 32'd30000);
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("trap.rst_flag", 32'(bad_addr), 32'd0);
    check("trap.rst_val", 32'(bad_addr_val), 32'd0);
    cyc();
`endif

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 4000; c++) begin
      int a;
      int rdy_pct;
      bit rst;
      rdy_pct = ((c / 500) % 3 == 0) ? 10 : (((c / 500) % 3 == 1) ? 40 : 85);
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 31);
        1: a = $urandom_range(16352, 16383);
        2: a = $urandom_range(16384, 16415);
        3: a = $urandom_range(24560, 24575);
        4: a = 24576;
        default: a = $urandom_range(24577, 32767);
      endcase
      rst = ($urandom_range(0, 199) == 0);
      drive(rst, a, rst ? 1'b0 : 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) < rdy_pct));
      #1;
      check_model("rnd");
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
